// File: rtl/state_sched_pkg.sv
// rtl/state_sched_pkg.sv - shared types and constants for the 1 ms frame scheduler
package state_sched_pkg;

   localparam int CHOICE_W = 4;
   localparam int DATA_W   = 16;

   // Host address that targets the frame repeat register instead of the table
   localparam logic [3:0] REP_ADDR = 4'd15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET,
      S_STB,
      S_HOLD,
      S_START,
      S_FRAME,
      S_DONE
   } state_t;

endpackage

// File: rtl/state_sched_timer.sv
// rtl/state_sched_timer.sv - frame period down-counter with load and expire
module state_sched_timer #(
   parameter int FRAME_CLKS = 10000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic expire
);

   // Holds at most FRAME_CLKS-2: the START cycle plus FRAME_CLKS-1 counted cycles make one period
   localparam int CNT_W = (FRAME_CLKS > 2) ? $clog2(FRAME_CLKS - 1) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FRAME_CLKS - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Reload on request, otherwise count down and park at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = RELOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/state_sched.sv
// rtl/state_sched.sv - config table loader and frame start sequencer for the 1 ms state engine
module state_sched
   import state_sched_pkg::*;
#(
   parameter int NCFG       = 6,
   parameter int FRAME_CLKS = 10000
) (
   input  logic                clk_sys,
   input  logic                state_sched_rst_n,
   input  logic                host_we,
   input  logic [3:0]          host_addr,
   input  logic [DATA_W-1:0]   host_wdata,
   input  logic                go,
   input  logic                abort,
   output logic                load,
   output logic [CHOICE_W-1:0] loadchoice,
   output logic [DATA_W-1:0]   datain,
   output logic                state_1ms_start,
   output logic                busy,
   output logic [15:0]         frame_cnt,
   output logic                done,
   output logic                err_wr
);

   state_t              state_q, state_d;
   logic [CHOICE_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0]   tbl_q [NCFG];
   logic [DATA_W-1:0]   tbl_d [NCFG];
   logic [15:0]         rep_q, rep_d;
   logic [15:0]         rep_run_q, rep_run_d;
   logic                load_q, load_d;
   logic [CHOICE_W-1:0] choice_q, choice_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                start_q, start_d;
   logic                busy_q, busy_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic                done_q, done_d;
   logic                err_wr_q, err_wr_d;

   logic                wr_ok;
   logic                rep_wr;
   logic                abort_run;
   logic [DATA_W-1:0]   rd_word;
   logic                timer_expire;

   state_sched_timer #(
      .FRAME_CLKS(FRAME_CLKS)
   ) u_timer (
      .clk    (clk_sys),
      .rst_n  (state_sched_rst_n),
      .load   (state_q == S_START),
      .expire (timer_expire)
   );

   assign wr_ok     = host_we && (state_q == S_IDLE);
   assign rep_wr    = wr_ok && (host_addr == REP_ADDR);
   assign abort_run = abort && (state_q != S_IDLE);

   // Table read port selected by the current word index
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NCFG; i++) begin
         if (idx_q == CHOICE_W'(i)) begin
            rd_word = tbl_q[i];
         end
      end
   end

   // Next state, host writes and registered output values
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      tbl_d       = tbl_q;
      rep_d       = rep_q;
      rep_run_d   = rep_run_q;
      choice_d    = choice_q;
      data_d      = data_q;
      frame_cnt_d = frame_cnt_q;

      for (int i = 0; i < NCFG; i++) begin
         if (wr_ok && host_addr == CHOICE_W'(i)) begin
            tbl_d[i] = host_wdata;
         end
      end
      if (rep_wr) begin
         rep_d = host_wdata;
      end

      // Outputs trail the state by one cycle so every port comes straight from a flop
      load_d   = (state_q == S_STB) && !abort_run;
      start_d  = (state_q == S_START) && !abort_run;
      done_d   = (state_q == S_DONE) && !abort_run;
      busy_d   = (state_q != S_IDLE);
      err_wr_d = host_we && (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (go && !abort) begin
               state_d     = S_SET;
               idx_d       = '0;
               frame_cnt_d = '0;
               // A repeat write in the go cycle counts for this run, like table writes
               rep_run_d   = rep_wr ? host_wdata : rep_q;
            end
         end
         S_SET: begin
            choice_d = idx_q;
            data_d   = rd_word;
            state_d  = S_STB;
         end
         S_STB: begin
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (idx_q < CHOICE_W'(NCFG - 1)) begin
               idx_d   = idx_q + CHOICE_W'(1);
               state_d = S_SET;
            end else begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (!abort_run && frame_cnt_q != 16'hFFFF) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
            end
            state_d = S_FRAME;
         end
         S_FRAME: begin
            if (timer_expire) begin
               // Zero repeat count means run until aborted
               if (rep_run_q == '0 || frame_cnt_q < rep_run_q) begin
                  state_d = S_START;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort_run) begin
         state_d = S_IDLE;
      end
   end

   // State, table and output registers
   always_ff @(posedge clk_sys or negedge state_sched_rst_n) begin
      if (!state_sched_rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         for (int i = 0; i < NCFG; i++) begin
            tbl_q[i] <= '0;
         end
         rep_q       <= 16'd1;
         rep_run_q   <= 16'd1;
         load_q      <= 1'b0;
         choice_q    <= '0;
         data_q      <= '0;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
         done_q      <= 1'b0;
         err_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         tbl_q       <= tbl_d;
         rep_q       <= rep_d;
         rep_run_q   <= rep_run_d;
         load_q      <= load_d;
         choice_q    <= choice_d;
         data_q      <= data_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         frame_cnt_q <= frame_cnt_d;
         done_q      <= done_d;
         err_wr_q    <= err_wr_d;
      end
   end

   assign load            = load_q;
   assign loadchoice      = choice_q;
   assign datain          = data_q;
   assign state_1ms_start = start_q;
   assign busy            = busy_q;
   assign frame_cnt       = frame_cnt_q;
   assign done            = done_q;
   assign err_wr          = err_wr_q;

endmodule

// File: tb/tb_state_sched.sv
// tb/tb_state_sched.sv - scoreboard bench for the 1 ms frame scheduler
module tb_state_sched;

   localparam int FC = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        host_we = 1'b0;
   logic [3:0]  host_addr = '0;
   logic [15:0] host_wdata = '0;
   logic        go = 1'b0;
   logic        abort = 1'b0;
   logic        load;
   logic [3:0]  loadchoice;
   logic [15:0] datain;
   logic        state_1ms_start;
   logic        busy;
   logic [15:0] frame_cnt;
   logic        done;
   logic        err_wr;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   int g;

   logic [63:0] exp_load [$];
   logic [63:0] exp_start [$];
   logic [63:0] exp_done [$];
   logic [15:0] tbl [6];

   state_sched #(
      .NCFG       (6),
      .FRAME_CLKS (FC)
   ) dut (
      .clk_sys           (clk),
      .state_sched_rst_n (rst_n),
      .host_we           (host_we),
      .host_addr         (host_addr),
      .host_wdata        (host_wdata),
      .go                (go),
      .abort             (abort),
      .load              (load),
      .loadchoice        (loadchoice),
      .datain            (datain),
      .state_1ms_start   (state_1ms_start),
      .busy              (busy),
      .frame_cnt         (frame_cnt),
      .done              (done),
      .err_wr            (err_wr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every pulse seen on the engine interface must match the queue head
   always @(negedge clk) begin
      if (load) begin
         if (exp_load.size() == 0) check("load_unexpected", 64'(edge_n), 64'hFFFF_FFFF);
         else check("load_event", {32'(edge_n), 12'h0, loadchoice, datain}, exp_load.pop_front());
      end
      if (state_1ms_start) begin
         if (exp_start.size() == 0) check("start_unexpected", 64'(edge_n), 64'hFFFF_FFFF);
         else check("start_event", 64'(edge_n), exp_start.pop_front());
      end
      if (done) begin
         if (exp_done.size() == 0) check("done_unexpected", 64'(edge_n), 64'hFFFF_FFFF);
         else check("done_event", 64'(edge_n), exp_done.pop_front());
      end
   end

   task automatic host_write(input logic [3:0] a, input logic [15:0] d);
      host_we = 1'b1;
      host_addr = a;
      host_wdata = d;
      @(negedge clk);
      host_we = 1'b0;
   endtask

   task automatic pulse_go(output int base);
      base = edge_n;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   // go sampled at edge index base: load k after edge base+3k+2, start i after base+19+i*FC
   task automatic push_run(input int base, input int nstarts, input bit with_done);
      for (int k = 0; k < 6; k++)
         exp_load.push_back({32'(base + 3 + 3 * k), 12'h0, 4'(k), tbl[k]});
      for (int i = 0; i < nstarts; i++)
         exp_start.push_back(64'(base + 20 + i * FC));
      if (with_done)
         exp_done.push_back(64'(base + 20 + nstarts * FC));
   endtask

   task automatic queues_empty(input string tag);
      check({tag, "_load_left"}, 64'(exp_load.size()), 64'd0);
      check({tag, "_start_left"}, 64'(exp_start.size()), 64'd0);
      check({tag, "_done_left"}, 64'(exp_done.size()), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 6; i++) tbl[i] = 16'h0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({load, loadchoice, datain, state_1ms_start, busy, frame_cnt, done, err_wr}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Two-frame run with a full table
      for (int i = 0; i < 6; i++) begin
         tbl[i] = 16'((i + 1) * 257);
         host_write(4'(i), tbl[i]);
      end
      host_write(4'd15, 16'd2);
      pulse_go(g);
      push_run(g, 2, 1'b1);
      @(negedge clk);
      check("t1_busy_high", 64'(busy), 64'd1);
      repeat (2 * FC + 30) @(negedge clk);
      check("t1_frame_cnt", 64'(frame_cnt), 64'd2);
      check("t1_busy_low", 64'(busy), 64'd0);
      queues_empty("t1");

      // Infinite mode, abort after the fifth frame start
      host_write(4'd15, 16'd0);
      pulse_go(g);
      push_run(g, 5, 1'b0);
      repeat (4 * FC + 22) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t2_busy_abort_edge", 64'(busy), 64'd1);
      @(negedge clk);
      check("t2_busy_after_abort", 64'(busy), 64'd0);
      repeat (FC + 10) @(negedge clk);
      check("t2_frame_cnt", 64'(frame_cnt), 64'd5);
      queues_empty("t2");

      // Write while busy is rejected and the old word survives into the next run
      host_write(4'd15, 16'd1);
      pulse_go(g);
      push_run(g, 1, 1'b1);
      repeat (3) @(negedge clk);
      host_write(4'd3, 16'hBEEF);
      check("t3_err_wr_pulse", 64'(err_wr), 64'd1);
      @(negedge clk);
      check("t3_err_wr_clear", 64'(err_wr), 64'd0);
      repeat (FC + 30) @(negedge clk);
      check("t3_frame_cnt", 64'(frame_cnt), 64'd1);
      queues_empty("t3a");
      pulse_go(g);
      push_run(g, 1, 1'b1);
      repeat (FC + 30) @(negedge clk);
      queues_empty("t3b");

      // go and abort together: nothing starts
      go = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      go = 1'b0;
      abort = 1'b0;
      check("t4_busy_next", 64'(busy), 64'd0);
      repeat (6) @(negedge clk);
      check("t4_busy_later", 64'(busy), 64'd0);
      check("t4_frame_cnt_kept", 64'(frame_cnt), 64'd1);

      // Asynchronous reset while the first word is strobed
      pulse_go(g);
      exp_load.push_back({32'(g + 3), 12'h0, 4'd0, tbl[0]});
      repeat (2) @(negedge clk);
      check("t5_load_before_reset", 64'(load), 64'd1);
      #2 rst_n = 1'b0;
      #1 check("t5_load_async_drop", 64'(load), 64'd0);
      check("t5_outputs_reset", 64'({load, loadchoice, datain, state_1ms_start, busy, frame_cnt, done, err_wr}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tbl[i] = 16'h0;
      @(negedge clk);
      pulse_go(g);
      push_run(g, 1, 1'b1);
      repeat (FC + 30) @(negedge clk);
      check("t5_frame_cnt", 64'(frame_cnt), 64'd1);
      queues_empty("t5");

      // Repeat write during the run does not extend it
      tbl[2] = 16'h1234;
      host_write(4'd2, tbl[2]);
      host_write(4'd15, 16'd1);
      pulse_go(g);
      push_run(g, 1, 1'b1);
      repeat (10) @(negedge clk);
      host_write(4'd15, 16'd3);
      check("t6_err_wr", 64'(err_wr), 64'd1);
      repeat (FC + 30) @(negedge clk);
      check("t6_frame_cnt", 64'(frame_cnt), 64'd1);
      check("t6_busy_low", 64'(busy), 64'd0);
      queues_empty("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
